// File: rtl/fix_point_div_if.sv
`default_nettype none
// ============================================================================
// Module   : fix_point_div_if
// Brief    : start/done handshake and operand/result bus of the Q16.16 divider
// Revision : 1.0
// ============================================================================
interface fix_point_div_if;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] c_o;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;
    logic        ovf_o;

    modport master (
        output start_i, a_i, b_i,
        input  c_o, busy_o, done_o, div_zero_o, ovf_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output c_o, busy_o, done_o, div_zero_o, ovf_o
    );
endinterface
`default_nettype wire

// File: rtl/fix_point_div.sv
`default_nettype none
// ============================================================================
// Module   : fix_point_div
// Brief    : sequential signed Q16.16 divider, restoring, one quotient bit/clk
// Revision : 1.0
// ============================================================================
module fix_point_div (
    input  wire              clk_i,
    input  wire              rst_i,
    fix_point_div_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_MAX_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] c_MAX_NEG = 32'h8000_0000;
    localparam logic [5:0]  c_LAST    = 6'd47;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        a_neg_q, a_neg_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [47:0] n_q, n_d;
    logic [31:0] r_q, r_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] c_q, c_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    // 32-bit unsigned magnitudes: -0x80000000 wraps to 0x80000000 = 2^31
    logic [31:0] w_a_mag, w_b_mag;
    assign w_a_mag = bus.a_i[31] ? (32'd0 - bus.a_i) : bus.a_i;
    assign w_b_mag = bus.b_i[31] ? (32'd0 - bus.b_i) : bus.b_i;

    // The remainder stays below |b| <= 2^31, so the shifted value fits 33 bits
    // and the difference always fits back into 32.
    logic [31:0] w_r_shift;
    logic        w_ge;
    logic [31:0] w_r_next;
    logic [47:0] w_q_next;
    assign w_r_shift = {r_q[30:0], n_q[47]};
    assign w_ge      = r_q[31] | (w_r_shift >= b_mag_q);
    assign w_r_next  = w_ge ? (w_r_shift - b_mag_q) : w_r_shift;
    assign w_q_next  = {n_q[46:0], w_ge};

    logic        w_ovf_pos, w_ovf_neg;
    assign w_ovf_pos = ~sign_q & (|w_q_next[47:31]);
    assign w_ovf_neg =  sign_q & (w_q_next > 48'h0000_8000_0000);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        a_neg_d  = a_neg_q;
        b_zero_d = b_zero_q;
        b_mag_d  = b_mag_q;
        n_d      = n_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        case (state_q)
            // DONE also accepts a start so a held start_i yields one result per 49 cycles
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start_i) begin
                    state_d  = S_RUN;
                    sign_d   = bus.a_i[31] ^ bus.b_i[31];
                    a_neg_d  = bus.a_i[31];
                    b_zero_d = (bus.b_i == 32'd0);
                    b_mag_d  = w_b_mag;
                    n_d      = {w_a_mag, 16'd0};
                    r_d      = 32'd0;
                    cnt_d    = (bus.b_i == 32'd0) ? 6'd0 : c_LAST;
                end
            end
            S_RUN: begin
                n_d   = w_q_next;
                r_d   = w_r_next;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (b_zero_q) begin
                        c_d   = a_neg_q ? c_MAX_NEG : c_MAX_POS;
                        dz_d  = 1'b1;
                        ovf_d = 1'b0;
                    end else if (w_ovf_pos) begin
                        c_d   = c_MAX_POS;
                        dz_d  = 1'b0;
                        ovf_d = 1'b1;
                    end else if (w_ovf_neg) begin
                        c_d   = c_MAX_NEG;
                        dz_d  = 1'b0;
                        ovf_d = 1'b1;
                    end else begin
                        c_d   = sign_q ? (32'd0 - w_q_next[31:0]) : w_q_next[31:0];
                        dz_d  = 1'b0;
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            b_mag_q  <= 32'd0;
            n_q      <= 48'd0;
            r_q      <= 32'd0;
            cnt_q    <= 6'd0;
            c_q      <= 32'd0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            a_neg_q  <= a_neg_d;
            b_zero_q <= b_zero_d;
            b_mag_q  <= b_mag_d;
            n_q      <= n_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.c_o        = c_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = done_q;
    assign bus.div_zero_o = dz_q;
    assign bus.ovf_o      = ovf_q;
endmodule
`default_nettype wire
